addr_bus_unit: RTL and testbench

- Downstream consumer of the X/Y/S register file's ADL/ADH bus drives, including the stack pointer placed on ADL.
- Holds the 16-bit external address bus as ABL/ABH registers.
- Forces page-0 and page-1 (stack page) high bytes and performs 16-bit or in-page increments.
- Contains a small sequencer that emits interrupt/reset vector address pairs.

---
 rtl/core6502_pkg.sv | 33 +++
 rtl/addr_bus_unit_if.sv | 49 ++++
 rtl/ab_vec_seq.sv | 83 ++++++++
 rtl/addr_bus_unit.sv | 80 ++++++++
 tb/tb_addr_bus_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core6502_pkg.sv
// Shared definitions for the address-bus unit: vector low bytes, VEC_SEL
// encodings, the vector sequencer state type and a vector decode helper.
package core6502_pkg;

  localparam logic [7:0] VEC_NMI = 8'hFA;
  localparam logic [7:0] VEC_RES = 8'hFC;
  localparam logic [7:0] VEC_IRQ = 8'hFE;

  localparam logic [1:0] SEL_NMI = 2'b00;
  localparam logic [1:0] SEL_RES = 2'b01;
  localparam logic [1:0] SEL_IRQ = 2'b10;
  localparam logic [1:0] SEL_BRK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } vec_state_e;

  // BRK shares the IRQ vector.
  function automatic logic [7:0] vec_byte(input logic [1:0] sel);
    logic [7:0] v;
    case (sel)
      SEL_NMI: v = VEC_NMI;
      SEL_RES: v = VEC_RES;
      SEL_IRQ: v = VEC_IRQ;
      SEL_BRK: v = VEC_IRQ;
      default: v = VEC_IRQ;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/addr_bus_unit_if.sv
// Bus interface of the address-bus unit. The core side (master) drives the
// internal buses and control strobes; the unit (slave) returns the external
// address, the sequencer flags and its state for observation.
// With AB_RDY_EN defined the interface carries the RDY stall input.
//
// Handshake: there is no valid/ready pair. Every control is a single-cycle
// level sampled on the rising PHI2 edge; RDY (when present) qualifies all
// of them, and a control sampled while RDY=0 is dropped, not held over.
interface addr_bus_unit_if;
  import core6502_pkg::*;

  logic [7:0]  ADL;
  logic [7:0]  ADH;
  logic        ADL_ABL;
  logic        ADH_ABH;
  logic        ADH_ZP;
  logic        ADH_SP;
  logic        AB_INC;
  logic        AB_INC_LO;
  logic        VEC_REQ;
  logic [1:0]  VEC_SEL;
`ifdef AB_RDY_EN
  logic        RDY;
`endif
  logic [15:0] AB;
  logic        VEC_BUSY;
  logic        VEC_LO_STB;
  logic        VEC_HI_STB;
  vec_state_e  seq_state;

  modport master (
    output ADL, ADH, ADL_ABL, ADH_ABH, ADH_ZP, ADH_SP, AB_INC, AB_INC_LO,
    output VEC_REQ, VEC_SEL,
`ifdef AB_RDY_EN
    output RDY,
`endif
    input  AB, VEC_BUSY, VEC_LO_STB, VEC_HI_STB, seq_state
  );

  modport slave (
    input  ADL, ADH, ADL_ABL, ADH_ABH, ADH_ZP, ADH_SP, AB_INC, AB_INC_LO,
    input  VEC_REQ, VEC_SEL,
`ifdef AB_RDY_EN
    input  RDY,
`endif
    output AB, VEC_BUSY, VEC_LO_STB, VEC_HI_STB, seq_state
  );

endinterface

// File: rtl/ab_vec_seq.sv
// Vector fetch sequencer: IDLE -> LO -> HI -> IDLE. Latches the vector low
// byte on request and tells the address register when it owns the bus and
// which address to write. Strobes and busy are registered Moore outputs.
module ab_vec_seq
  import core6502_pkg::*;
#(
  parameter logic [7:0] VEC_PAGE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        vec_req,
  input  logic [1:0]  vec_sel,
  output logic        own,
  output logic        ab_wr,
  output logic [15:0] vec_ab,
  output logic        busy,
  output logic        lo_stb,
  output logic        hi_stb,
  output vec_state_e  state
);

  logic [7:0] vec_q;

  // Bus ownership and vector address for the coming edge. In HI the
  // sequencer still owns the bus but writes nothing, so AB holds FFxx|1.
  always_comb begin
    own    = (state != IDLE) || vec_req;
    ab_wr  = 1'b0;
    vec_ab = {VEC_PAGE, vec_byte(vec_sel)};
    case (state)
      IDLE: ab_wr = vec_req;
      LO: begin
        ab_wr  = 1'b1;
        vec_ab = {VEC_PAGE, vec_q | 8'h01};
      end
      HI:      ab_wr = 1'b0;
      default: ab_wr = 1'b0;
    endcase
  end

  // State, vector latch and decoded outputs; everything frozen while rdy=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      vec_q  <= 8'h00;
      busy   <= 1'b0;
      lo_stb <= 1'b0;
      hi_stb <= 1'b0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (vec_req) begin
            vec_q  <= vec_byte(vec_sel);
            state  <= LO;
            busy   <= 1'b1;
            lo_stb <= 1'b1;
            hi_stb <= 1'b0;
          end
        end
        LO: begin
          state  <= HI;
          busy   <= 1'b1;
          lo_stb <= 1'b0;
          hi_stb <= 1'b1;
        end
        HI: begin
          state  <= IDLE;
          busy   <= 1'b0;
          lo_stb <= 1'b0;
          hi_stb <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          lo_stb <= 1'b0;
          hi_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/addr_bus_unit.sv
// External address bus registers ABL/ABH with zero-page / stack-page
// forcing, 16-bit and in-page increments, and vector fetch sequencing.
// Priority: vector sequencer, then loads, then AB_INC, then AB_INC_LO.
// Optional macro AB_RDY_EN adds the RDY stall input.
module addr_bus_unit
  import core6502_pkg::*;
#(
  parameter logic [7:0] VEC_PAGE   = 8'hFF,
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic            PHI2,
  input  logic            RES,
  addr_bus_unit_if.slave  bus
);

  logic        rdy;
  logic        seq_own;
  logic        seq_wr;
  logic [15:0] seq_ab;
  logic [7:0]  abl;
  logic [7:0]  abh;
  logic [7:0]  abh_src;
  logic        any_load;

`ifdef AB_RDY_EN
  assign rdy = bus.RDY;
`else
  assign rdy = 1'b1;
`endif

  ab_vec_seq #(
    .VEC_PAGE (VEC_PAGE)
  ) u_seq (
    .clk     (PHI2),
    .rst     (RES),
    .rdy     (rdy),
    .vec_req (bus.VEC_REQ),
    .vec_sel (bus.VEC_SEL),
    .own     (seq_own),
    .ab_wr   (seq_wr),
    .vec_ab  (seq_ab),
    .busy    (bus.VEC_BUSY),
    .lo_stb  (bus.VEC_LO_STB),
    .hi_stb  (bus.VEC_HI_STB),
    .state   (bus.seq_state)
  );

  // High-byte source for a load: zero page beats stack page beats ADH.
  always_comb begin
    abh_src  = bus.ADH;
    any_load = bus.ADL_ABL || bus.ADH_ABH;
    if (bus.ADH_ZP)      abh_src = 8'h00;
    else if (bus.ADH_SP) abh_src = STACK_PAGE;
  end

  // Address register update with the fixed priority order.
  always_ff @(posedge PHI2 or posedge RES) begin
    if (RES) begin
      abl <= 8'h00;
      abh <= 8'h00;
    end else if (rdy) begin
      if (seq_own) begin
        if (seq_wr) begin
          abh <= seq_ab[15:8];
          abl <= seq_ab[7:0];
        end
      end else if (any_load) begin
        if (bus.ADL_ABL) abl <= bus.ADL;
        if (bus.ADH_ABH) abh <= abh_src;
      end else if (bus.AB_INC) begin
        {abh, abl} <= {abh, abl} + 16'd1;
      end else if (bus.AB_INC_LO) begin
        abl <= abl + 8'd1;
      end
    end
  end

  assign bus.AB = {abh, abl};

endmodule

// File: tb/tb_addr_bus_unit.sv
// Bench for addr_bus_unit: directed vector table, hand sequences for reset
// and RDY corner cases, and random traffic against a queue-based model.
module tb_addr_bus_unit;
  import core6502_pkg::*;

  typedef struct {
    logic [7:0] adl;
    logic [7:0] adh;
    logic       abl;
    logic       abh;
    logic       zp;
    logic       sp;
    logic       inc;
    logic       inc_lo;
    logic       vreq;
    logic [1:0] vsel;
  } in_t;

  typedef struct {
    in_t         i;
    logic [15:0] ab;
    logic        busy;
    logic        lo;
    logic        hi;
  } row_t;

  typedef struct {
    bit          use_ab;
    logic [15:0] ab;
    bit          lo;
    bit          hi;
  } pend_t;

  logic PHI2 = 1'b0;
  logic RES;
  int   n_tests = 0;
  int   n_fail  = 0;

  addr_bus_unit_if bus ();

  addr_bus_unit dut (
    .PHI2 (PHI2),
    .RES  (RES),
    .bus  (bus)
  );

  // ---------------- clock ----------------
  always #5 PHI2 = ~PHI2;

  // ---------------- model and scoreboard ----------------
  logic [15:0] m_ab;
  bit          m_lo;
  bit          m_hi;
  pend_t       pend_q[$];
  logic [18:0] exp_q[$];

  function automatic in_t ctl(input logic [7:0] adl, input logic [7:0] adh,
                              input logic [6:0] f, input logic [1:0] sel);
    in_t x;
    x.adl = adl; x.adh = adh;
    {x.abl, x.abh, x.zp, x.sp, x.inc, x.inc_lo, x.vreq} = f;
    x.vsel = sel;
    return x;
  endfunction

  task automatic model_reset();
    m_ab = 16'h0000; m_lo = 0; m_hi = 0;
    pend_q.delete();
    exp_q.delete();
  endtask

  // One PHI2 edge of the address unit, described as "a vector request books
  // the next two cycles; otherwise the highest-priority control applies".
  task automatic model_step(input in_t x, input bit rdy);
    pend_t p;
    logic [7:0] v;
    logic [7:0] hi_b;
    if (rdy) begin
      m_lo = 0; m_hi = 0;
      if (pend_q.size() > 0) begin
        p = pend_q.pop_front();
        if (p.use_ab) m_ab = p.ab;
        m_lo = p.lo; m_hi = p.hi;
      end else if (x.vreq) begin
        v = (x.vsel == 2'd0) ? 8'hFA : (x.vsel == 2'd1) ? 8'hFC : 8'hFE;
        m_ab = 16'hFF00 + 16'(v);
        m_lo = 1;
        pend_q.push_back('{1'b1, 16'hFF00 + 16'(v) + 16'd1, 1'b0, 1'b1});
        pend_q.push_back('{1'b0, 16'h0000, 1'b0, 1'b0});
      end else if (x.abl || x.abh) begin
        if (x.abh) begin
          hi_b = x.zp ? 8'h00 : (x.sp ? 8'h01 : x.adh);
          m_ab = {hi_b, m_ab[7:0]};
        end
        if (x.abl) m_ab = {m_ab[15:8], x.adl};
      end else if (x.inc) begin
        m_ab = 16'((32'(m_ab) + 1) % 65536);
      end else if (x.inc_lo) begin
        m_ab = (m_ab & 16'hFF00) | 16'((32'(m_ab) + 1) % 256);
      end
    end
    exp_q.push_back({m_ab, m_lo | m_hi, m_lo, m_hi});
  endtask

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ab=%h busy=%b lo=%b hi=%b, expected ab=%h busy=%b lo=%b hi=%b",
               name, act[18:3], act[2], act[1], act[0], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [18:0] dut_out();
    return {bus.AB, bus.VEC_BUSY, bus.VEC_LO_STB, bus.VEC_HI_STB};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input in_t x, input bit rdy);
    bus.ADL = x.adl; bus.ADH = x.adh;
    bus.ADL_ABL = x.abl; bus.ADH_ABH = x.abh;
    bus.ADH_ZP = x.zp; bus.ADH_SP = x.sp;
    bus.AB_INC = x.inc; bus.AB_INC_LO = x.inc_lo;
    bus.VEC_REQ = x.vreq; bus.VEC_SEL = x.vsel;
`ifdef AB_RDY_EN
    bus.RDY = rdy;
`endif
  endtask

  // Drive, clock once, compare #1 after the edge.
  task automatic cycle_exp(input string name, input in_t x, input bit rdy,
                           input logic [18:0] exp);
    drive(x, rdy);
    @(posedge PHI2);
    #1;
    check(name, dut_out(), exp);
  endtask

  task automatic cycle_model(input string name, input in_t x, input bit rdy);
    logic [18:0] e;
    drive(x, rdy);
    model_step(x, rdy);
    @(posedge PHI2);
    #1;
    e = exp_q.pop_front();
    check(name, dut_out(), e);
  endtask

  task automatic do_reset();
    drive(ctl(8'h00, 8'h00, 7'b0, 2'b00), 1'b1);
    @(negedge PHI2);
    RES = 1'b1;
    #1;
    check("reset_state", dut_out(), 19'h0);
    @(posedge PHI2);
    #1;
    RES = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  row_t tbl[$];
  in_t  idle_in;

  initial begin
    RES = 1'b0;
    idle_in = ctl(8'h00, 8'h00, 7'b0, 2'b00);
    //                  adl    adh    {abl,abh,zp,sp,inc,inc_lo,vreq} sel   ab   busy lo hi
    tbl.push_back('{ctl(8'h34, 8'h12, 7'b1100000, 2'd0), 16'h1234, 0, 0, 0});
    tbl.push_back('{ctl(8'hFD, 8'h77, 7'b1101000, 2'd0), 16'h01FD, 0, 0, 0});
    tbl.push_back('{ctl(8'hFD, 8'h77, 7'b1111000, 2'd0), 16'h00FD, 0, 0, 0});
    tbl.push_back('{ctl(8'h00, 8'hAA, 7'b0100000, 2'd0), 16'hAAFD, 0, 0, 0});
    tbl.push_back('{ctl(8'hFF, 8'h33, 7'b1011000, 2'd0), 16'hAAFF, 0, 0, 0});
    tbl.push_back('{ctl(8'hFF, 8'h12, 7'b1100000, 2'd0), 16'h12FF, 0, 0, 0});
    tbl.push_back('{ctl(8'h00, 8'h00, 7'b0000100, 2'd0), 16'h1300, 0, 0, 0});
    tbl.push_back('{ctl(8'hFF, 8'h12, 7'b1100000, 2'd0), 16'h12FF, 0, 0, 0});
    tbl.push_back('{ctl(8'h00, 8'h00, 7'b0000010, 2'd0), 16'h1200, 0, 0, 0});
    tbl.push_back('{ctl(8'hFF, 8'hFF, 7'b1100000, 2'd0), 16'hFFFF, 0, 0, 0});
    tbl.push_back('{ctl(8'h00, 8'h00, 7'b0000100, 2'd0), 16'h0000, 0, 0, 0});
    tbl.push_back('{ctl(8'h00, 8'h00, 7'b0000110, 2'd0), 16'h0001, 0, 0, 0});
    tbl.push_back('{ctl(8'hFF, 8'h12, 7'b1100000, 2'd0), 16'h12FF, 0, 0, 0});
    tbl.push_back('{ctl(8'h55, 8'h99, 7'b1000100, 2'd0), 16'h1255, 0, 0, 0});
    tbl.push_back('{ctl(8'h00, 8'h00, 7'b0001010, 2'd0), 16'h1256, 0, 0, 0});
    tbl.push_back('{ctl(8'h00, 8'h00, 7'b0000001, 2'd0), 16'hFFFA, 1, 1, 0});
    tbl.push_back('{ctl(8'h11, 8'h22, 7'b1100101, 2'd2), 16'hFFFB, 1, 0, 1});
    tbl.push_back('{ctl(8'h11, 8'h22, 7'b1100001, 2'd1), 16'hFFFB, 0, 0, 0});
    tbl.push_back('{ctl(8'h00, 8'h00, 7'b0000000, 2'd0), 16'hFFFB, 0, 0, 0});
    tbl.push_back('{ctl(8'h00, 8'h00, 7'b0000001, 2'd3), 16'hFFFE, 1, 1, 0});
    tbl.push_back('{ctl(8'h00, 8'h00, 7'b0000000, 2'd0), 16'hFFFF, 1, 0, 1});
    tbl.push_back('{ctl(8'h00, 8'h00, 7'b0000000, 2'd0), 16'hFFFF, 0, 0, 0});
    tbl.push_back('{ctl(8'h00, 8'h00, 7'b0000100, 2'd0), 16'h0000, 0, 0, 0});

    do_reset();
    foreach (tbl[k])
      cycle_exp($sformatf("table_%0d", k), tbl[k].i, 1'b1,
                {tbl[k].ab, tbl[k].busy, tbl[k].lo, tbl[k].hi});

    // RES vector, then reset asserted in the middle of the HI cycle.
    do_reset();
    cycle_exp("res_vec_lo", ctl(8'h00, 8'h00, 7'b0000001, 2'd1), 1'b1, {16'hFFFC, 3'b110});
    cycle_exp("res_vec_hi", idle_in, 1'b1, {16'hFFFD, 3'b101});
    #2;
    RES = 1'b1;
    #1;
    check("async_abort", dut_out(), 19'h0);
    @(posedge PHI2);
    #1;
    RES = 1'b0;
    cycle_exp("after_abort", idle_in, 1'b1, 19'h0);

`ifdef AB_RDY_EN
    // IRQ vector stalled in LO: requests and increments dropped meanwhile.
    do_reset();
    cycle_exp("rdy_lo", ctl(8'h00, 8'h00, 7'b0000001, 2'd2), 1'b1, {16'hFFFE, 3'b110});
    for (int s = 0; s < 3; s++)
      cycle_exp($sformatf("rdy_stall_%0d", s), ctl(8'h42, 8'h42, 7'b1100101, 2'd0), 1'b0,
                {16'hFFFE, 3'b110});
    cycle_exp("rdy_hi", idle_in, 1'b1, {16'hFFFF, 3'b101});
    cycle_exp("rdy_idle", idle_in, 1'b1, {16'hFFFF, 3'b000});
    cycle_exp("rdy_drop_load", ctl(8'h42, 8'h42, 7'b1100000, 2'd0), 1'b0, {16'hFFFF, 3'b000});
`endif

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      in_t x;
      bit  r;
      x.adl    = 8'($urandom_range(0, 255));
      x.adh    = 8'($urandom_range(0, 255));
      x.abl    = ($urandom_range(0, 3) == 0);
      x.abh    = ($urandom_range(0, 3) == 0);
      x.zp     = ($urandom_range(0, 2) == 0);
      x.sp     = ($urandom_range(0, 2) == 0);
      x.inc    = ($urandom_range(0, 2) == 0);
      x.inc_lo = ($urandom_range(0, 2) == 0);
      x.vreq   = ($urandom_range(0, 7) == 0);
      x.vsel   = 2'($urandom_range(0, 3));
`ifdef AB_RDY_EN
      r = ($urandom_range(0, 3) != 0);
`else
      r = 1'b1;
`endif
      cycle_model($sformatf("rand_%0d", n), x, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
